// File: rtl/mem_pkg.sv
// Shared constants, MEM/WB payload and load-lane helper for the memory stage.
package mem_pkg;

   localparam int unsigned XLEN_C = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef struct packed {
      logic              reg_write;
      logic [1:0]        result_src;
      logic [4:0]        rd;
      logic [XLEN_C-1:0] pc_plus4;
      logic [XLEN_C-1:0] alu_result;
      logic [XLEN_C-1:0] read_data;
      logic              fault;
   } mw_reg_t;

   // Pick the addressed byte/halfword/word and extend it; illegal sizes give 0.
   function automatic logic [XLEN_C-1:0] lane_extract(input logic [XLEN_C-1:0] word,
                                                      input logic [1:0]        offset,
                                                      input logic [2:0]        funct3);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{offset, 3'b000} +: 8];
      h = offset[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    lane_extract = {{24{b[7]}}, b};
         F3_H:    lane_extract = {{16{h[15]}}, h};
         F3_W:    lane_extract = word;
         F3_BU:   lane_extract = {24'd0, b};
         F3_HU:   lane_extract = {16'd0, h};
         default: lane_extract = '0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_bhw_dmem_be.sv
// Word-organised data memory: byte-enable synchronous write, asynchronous read.
module dmem_be #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic [3:0]        we_be_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [XLEN-1:0]   rdata_c
);

   logic [XLEN-1:0] mem_q [DEPTH];

   // Each enabled lane is written independently; the rest of the word is kept.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we_be_i[b]) begin
            mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/mem_stage_bhw.sv
// RISC-V MEM stage with sized loads/stores, fault detection and MEM/WB register.
// Optional macro DMEM_BOUNDS_CHECK_EN faults accesses beyond the memory instead of wrapping.
module mem_stage_bhw
   import mem_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DMEM_DEPTH = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallW,
   input  logic            FlushW,
   input  logic            RegWriteM,
   input  logic            MemWriteM,
   input  logic [1:0]      ResultSrcM,
   input  logic [2:0]      Funct3M,
   input  logic [4:0]      RD_M,
   input  logic [XLEN-1:0] PCPlus4M,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [XLEN-1:0] ALU_ResultM,
   output logic            RegWriteW,
   output logic [1:0]      ResultSrcW,
   output logic [4:0]      RD_W,
   output logic [XLEN-1:0] PCPlus4W,
   output logic [XLEN-1:0] ALU_ResultW,
   output logic [XLEN-1:0] ReadDataW,
   output logic            FaultW
);

   localparam int unsigned ADDR_W = $clog2(DMEM_DEPTH);

   if (XLEN != 32) begin : g_bad_xlen
      $error("mem_stage_bhw: XLEN must be 32");
   end
   if ((DMEM_DEPTH < 4) || ((DMEM_DEPTH & (DMEM_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("mem_stage_bhw: DMEM_DEPTH must be a power of two >= 4");
   end

   logic [1:0]        off;
   logic [ADDR_W-1:0] word_idx;
   logic              is_load;
   logic              mem_act;
   logic              size_bad;
   logic              misalign;
   logic              oob;
   logic              fault;
   logic              store_ok;
   logic [3:0]        be;
   logic [XLEN-1:0]   wdata;
   logic [XLEN-1:0]   rdata;
   logic [XLEN-1:0]   load_data;
   mw_reg_t           mw_d;
   mw_reg_t           mw_q;

   assign off      = ALU_ResultM[1:0];
   assign word_idx = ALU_ResultM[ADDR_W+1:2];
   assign is_load  = (ResultSrcM == RES_MEM);
   assign mem_act  = MemWriteM | is_load;

`ifdef DMEM_BOUNDS_CHECK_EN
   assign oob = |ALU_ResultM[XLEN-1:ADDR_W+2];
`else
   logic unused_addr_hi;
   assign oob            = 1'b0;
   assign unused_addr_hi = ^ALU_ResultM[XLEN-1:ADDR_W+2];
`endif

   // Size legality and natural alignment; stores only encode sizes 00..10.
   always_comb begin
      size_bad = 1'b0;
      misalign = 1'b0;
      case (Funct3M)
         F3_B, F3_H, F3_W, F3_BU, F3_HU: size_bad = 1'b0;
         default:                        size_bad = 1'b1;
      endcase
      if (MemWriteM && Funct3M[2]) begin
         size_bad = 1'b1;
      end
      if ((Funct3M[1:0] == 2'b01) && off[0]) begin
         misalign = 1'b1;
      end
      if ((Funct3M[1:0] == 2'b10) && (off != 2'b00)) begin
         misalign = 1'b1;
      end
   end

   assign fault    = mem_act & (size_bad | misalign | oob);
   assign store_ok = MemWriteM & ~fault & ~StallW & ~FlushW & rst;

   // Lane enables and replicated store data so any lane can take the low bits.
   always_comb begin
      be    = 4'b0000;
      wdata = WriteDataM;
      case (Funct3M[1:0])
         2'b00: begin
            be    = 4'b0001 << off;
            wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << off;
            wdata = {2{WriteDataM[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      if (!store_ok) begin
         be = 4'b0000;
      end
   end

   dmem_be #(
      .XLEN   (XLEN),
      .DEPTH  (DMEM_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_dmem (
      .clk     (clk),
      .we_be_i (be),
      .waddr_i (word_idx),
      .wdata_i (wdata),
      .raddr_i (word_idx),
      .rdata_c (rdata)
   );

   assign load_data = (is_load && !fault) ? lane_extract(rdata, off, Funct3M) : '0;

   // MEM/WB next state: flush beats stall, stall holds.
   always_comb begin
      mw_d = mw_q;
      if (FlushW) begin
         mw_d = '0;
      end else if (!StallW) begin
         mw_d.reg_write  = RegWriteM & ~fault;
         mw_d.result_src = ResultSrcM;
         mw_d.rd         = RD_M;
         mw_d.pc_plus4   = PCPlus4M;
         mw_d.alu_result = ALU_ResultM;
         mw_d.read_data  = load_data;
         mw_d.fault      = fault;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mw_q <= '0;
      end else begin
         mw_q <= mw_d;
      end
   end

   assign RegWriteW   = mw_q.reg_write;
   assign ResultSrcW  = mw_q.result_src;
   assign RD_W        = mw_q.rd;
   assign PCPlus4W    = mw_q.pc_plus4;
   assign ALU_ResultW = mw_q.alu_result;
   assign ReadDataW   = mw_q.read_data;
   assign FaultW      = mw_q.fault;

endmodule
